// File: rtl/vm2002_pkg.sv
// Shared vending-machine types: coin encoding, coin values and the change
// dispenser state encoding.
package vm2002_pkg;

    typedef enum logic [1:0] {
        NICKEL      = 2'd0,
        DIME        = 2'd1,
        QUARTER     = 2'd2,
        ILLEGALCOIN = 2'd3
    } coin_t;

    localparam logic [7:0] COIN_VAL_NICKEL  = 8'd5;
    localparam logic [7:0] COIN_VAL_DIME    = 8'd10;
    localparam logic [7:0] COIN_VAL_QUARTER = 8'd25;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } chg_state_t;

    function automatic logic [7:0] coin_value(input coin_t c);
        logic [7:0] v;
        case (c)
            NICKEL:  v = COIN_VAL_NICKEL;
            DIME:    v = COIN_VAL_DIME;
            QUARTER: v = COIN_VAL_QUARTER;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// Per-denomination coin counts: refilled by accepted coins, decremented by
// dispensed coins, saturating at both ends.
module vm2002_coin_inventory
    import vm2002_pkg::*;
#(
    parameter int INV_W  = 8,
    parameter int INIT_Q = 20,
    parameter int INIT_D = 20,
    parameter int INIT_N = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_refill_valid,
    input  logic [1:0]       i_refill_coin,
    input  logic             i_dec_valid,
    input  logic [1:0]       i_dec_coin,
    output logic [INV_W-1:0] o_inv_q,
    output logic [INV_W-1:0] o_inv_d,
    output logic [INV_W-1:0] o_inv_n
);

    logic [INV_W-1:0] r_inv_q;
    logic [INV_W-1:0] r_inv_d;
    logic [INV_W-1:0] r_inv_n;

    logic w_inc_q;
    logic w_inc_d;
    logic w_inc_n;
    logic w_dec_q;
    logic w_dec_d;
    logic w_dec_n;

    // A refill and a dispense of the same coin cancel out, even at saturation.
    function automatic logic [INV_W-1:0] next_count(
        input logic [INV_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [INV_W-1:0] n;
        n = cnt;
        if (inc && !dec) begin
            if (cnt != '1) n = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt != '0) n = cnt - 1'b1;
        end
        return n;
    endfunction

    assign w_inc_q = i_refill_valid && (i_refill_coin == QUARTER);
    assign w_inc_d = i_refill_valid && (i_refill_coin == DIME);
    assign w_inc_n = i_refill_valid && (i_refill_coin == NICKEL);
    assign w_dec_q = i_dec_valid && (i_dec_coin == QUARTER);
    assign w_dec_d = i_dec_valid && (i_dec_coin == DIME);
    assign w_dec_n = i_dec_valid && (i_dec_coin == NICKEL);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_inv_q <= INV_W'(INIT_Q);
            r_inv_d <= INV_W'(INIT_D);
            r_inv_n <= INV_W'(INIT_N);
        end else begin
            r_inv_q <= next_count(r_inv_q, w_inc_q, w_dec_q);
            r_inv_d <= next_count(r_inv_d, w_inc_d, w_dec_d);
            r_inv_n <= next_count(r_inv_n, w_inc_n, w_dec_n);
        end
    end

    assign o_inv_q = r_inv_q;
    assign o_inv_d = r_inv_d;
    assign o_inv_n = r_inv_n;

endmodule

// File: rtl/vm2002_change_dispenser.sv
// Change dispenser: pays a captured amount greedily (Q, D, N) one coin at a
// time over a valid/ready chute, then reports completion and any shortfall.
module vm2002_change_dispenser
    import vm2002_pkg::*;
#(
    parameter int INV_W  = 8,
    parameter int INIT_Q = 20,
    parameter int INIT_D = 20,
    parameter int INIT_N = 20
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [7:0]       i_req_amount,
    output logic             o_coin_valid,
    input  logic             i_coin_ready,
    output logic [1:0]       o_coin_out,
    output logic             o_done,
    output logic             o_short,
    output logic [7:0]       o_remaining,
    input  logic             i_refill_valid,
    input  logic [1:0]       i_refill_coin,
    output logic [INV_W-1:0] o_inv_q,
    output logic [INV_W-1:0] o_inv_d,
    output logic [INV_W-1:0] o_inv_n,
    output logic [1:0]       o_state
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both
    // high; coin_out is held stable from coin_valid rising until that cycle.

    chg_state_t r_state;
    chg_state_t w_state_nxt;
    logic [7:0] r_rem;
    logic [7:0] w_rem_nxt;
    coin_t      r_coin;
    coin_t      w_coin_nxt;
    logic       r_done;
    logic       r_short;
    logic [7:0] r_remaining;

    logic             w_sel_found;
    coin_t            w_sel_coin;
    logic             w_dec_valid;
    logic [INV_W-1:0] w_inv_q;
    logic [INV_W-1:0] w_inv_d;
    logic [INV_W-1:0] w_inv_n;

    vm2002_coin_inventory #(
        .INV_W  (INV_W),
        .INIT_Q (INIT_Q),
        .INIT_D (INIT_D),
        .INIT_N (INIT_N)
    ) u_inventory (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_refill_valid (i_refill_valid),
        .i_refill_coin  (i_refill_coin),
        .i_dec_valid    (w_dec_valid),
        .i_dec_coin     (r_coin),
        .o_inv_q        (w_inv_q),
        .o_inv_d        (w_inv_d),
        .o_inv_n        (w_inv_n)
    );

    // Greedy pick: the largest coin that fits in rem and is in stock.
    always_comb begin
        w_sel_found = 1'b1;
        w_sel_coin  = NICKEL;
        if (r_rem >= COIN_VAL_QUARTER && w_inv_q != '0) begin
            w_sel_coin = QUARTER;
        end else if (r_rem >= COIN_VAL_DIME && w_inv_d != '0) begin
            w_sel_coin = DIME;
        end else if (r_rem >= COIN_VAL_NICKEL && w_inv_n != '0) begin
            w_sel_coin = NICKEL;
        end else begin
            w_sel_found = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_coin_nxt  = r_coin;
        w_dec_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req_valid) begin
                    w_rem_nxt   = i_req_amount;
                    w_state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (w_sel_found) begin
                    w_coin_nxt  = w_sel_coin;
                    w_state_nxt = DISPENSE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            DISPENSE: begin
                if (i_coin_ready) begin
                    w_rem_nxt   = r_rem - coin_value(r_coin);
                    w_dec_valid = 1'b1;
                    w_state_nxt = SELECT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_rem       <= 8'd0;
            r_coin      <= NICKEL;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
            r_remaining <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_rem       <= w_rem_nxt;
            r_coin      <= w_coin_nxt;
            // Completion outputs are loaded on entry to DONE, so they live one cycle.
            r_done      <= (w_state_nxt == DONE);
            r_short     <= (w_state_nxt == DONE) && (r_rem != 8'd0);
            r_remaining <= (w_state_nxt == DONE) ? r_rem : 8'd0;
        end
    end

    assign o_req_ready  = (r_state == IDLE);
    assign o_coin_valid = (r_state == DISPENSE);
    assign o_coin_out   = r_coin;
    assign o_done       = r_done;
    assign o_short      = r_short;
    assign o_remaining  = r_remaining;
    assign o_inv_q      = w_inv_q;
    assign o_inv_d      = w_inv_d;
    assign o_inv_n      = w_inv_n;
    assign o_state      = r_state;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for the change dispenser: directed cases plus random requests, checked
// by a greedy-payout reference model through an expected-response queue.
module tb_vm2002_change_dispenser;
    import vm2002_pkg::*;

    localparam int INV_MAX = 255;
    localparam int INIT_C  = 20;
    localparam int W       = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_amount = 8'd0;
    logic       coin_valid;
    logic       coin_ready = 1'b0;
    logic [1:0] coin_out;
    logic       done;
    logic       short_o;
    logic [7:0] remaining;
    logic       refill_valid = 1'b0;
    logic [1:0] refill_coin = 2'd0;
    logic [7:0] inv_q;
    logic [7:0] inv_d;
    logic [7:0] inv_n;
    logic [1:0] state;

    vm2002_change_dispenser #(
        .INV_W (8), .INIT_Q (INIT_C), .INIT_D (INIT_C), .INIT_N (INIT_C)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_amount   (req_amount),
        .o_coin_valid   (coin_valid),
        .i_coin_ready   (coin_ready),
        .o_coin_out     (coin_out),
        .o_done         (done),
        .o_short        (short_o),
        .o_remaining    (remaining),
        .i_refill_valid (refill_valid),
        .i_refill_coin  (refill_coin),
        .o_inv_q        (inv_q),
        .o_inv_d        (inv_d),
        .o_inv_n        (inv_n),
        .o_state        (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int m_inv[3];

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] coin_entry(input logic [1:0] c);
        return {1'b0, c, 9'd0};
    endfunction

    function automatic logic [W-1:0] done_entry(input logic s, input logic [7:0] r);
        return {1'b1, 2'b00, s, r};
    endfunction

    // Greedy payout from the model inventory, indexed by coin code.
    function automatic void model_request(input int amt);
        int vals[3];
        int rem;
        bit progress;
        vals = '{5, 10, 25};
        rem = amt;
        progress = 1'b1;
        while (progress) begin
            progress = 1'b0;
            for (int c = 2; c >= 0; c--) begin
                if (!progress && rem >= vals[c] && m_inv[c] > 0) begin
                    rem -= vals[c];
                    m_inv[c]--;
                    exp_q.push_back(coin_entry(2'(c)));
                    progress = 1'b1;
                end
            end
        end
        exp_q.push_back(done_entry(rem != 0, 8'(rem)));
    endfunction

    function automatic void model_refill(input logic [1:0] c);
        if (c != ILLEGALCOIN && m_inv[c] < INV_MAX) m_inv[c]++;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) m_inv[c] = INIT_C;
    endfunction

    // ---------------- monitor ----------------
    int         last_hs = 0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic       prev_done = 1'b0;
    logic [1:0] prev_coin = 2'd0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("coin_valid_hold", int'(coin_valid), 1);
                check("coin_out_hold", int'(coin_out), int'(prev_coin));
            end
            if (coin_valid && !prev_valid) check("coin_latency", cyc - last_hs, 2);
            if (done) check("done_latency", cyc - last_hs, 2);
            if (prev_done) check("ready_after_done", int'(req_ready), 1);
            if (coin_valid && coin_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_coin", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("coin", int'(coin_entry(coin_out)), int'(e));
                end
                last_hs = cyc;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", int'(done_entry(short_o, remaining)), int'(e));
                end
            end
            if (req_valid && req_ready) last_hs = cyc;
            prev_valid = coin_valid;
            prev_stall = coin_valid && !coin_ready;
            prev_coin  = coin_out;
            prev_done  = done;
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic check_inv(input string tag);
        check({tag, "_inv_q"}, int'(inv_q), m_inv[2]);
        check({tag, "_inv_d"}, int'(inv_d), m_inv[1]);
        check({tag, "_inv_n"}, int'(inv_n), m_inv[0]);
    endtask

    task automatic refill(input logic [1:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            refill_valid = 1'b1;
            refill_coin  = c;
            model_refill(c);
            @(posedge clk); #1;
        end
        refill_valid = 1'b0;
    endtask

    task automatic do_request(input int amt, input int low, input bit rnd,
                              input bit refill_q, input bit hold_chk,
                              output int valid_cycles);
        int cnt;
        int wait_cnt;
        int q0;
        cnt = 0;
        while (!req_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("req_ready_wait", int'(req_ready), 1);
        q0 = m_inv[2];
        model_request(amt);
        req_valid  = 1'b1;
        req_amount = 8'(amt);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_amount = 8'($urandom);
        wait_cnt = 0;
        valid_cycles = 0;
        cnt = 0;
        while (!done && cnt < 400) begin
            if (coin_valid) begin
                valid_cycles++;
                if (hold_chk) check("inv_q_before_handshake", int'(inv_q), q0);
                coin_ready = rnd ? 1'($urandom_range(0, 1)) : (wait_cnt >= low);
                if (refill_q && coin_ready) begin
                    refill_valid = 1'b1;
                    refill_coin  = QUARTER;
                    model_refill(QUARTER);
                end
                wait_cnt = coin_ready ? 0 : wait_cnt + 1;
            end else begin
                coin_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk); #1;
            refill_valid = 1'b0;
            cnt++;
        end
        coin_ready = 1'b0;
        check("done_seen", int'(done), 1);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vc;
        int guard;
        int amt;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_coin_valid", int'(coin_valid), 0);
        check("rst_coin_out", int'(coin_out), int'(NICKEL));
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short_o), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_state", int'(state), 0);
        check_inv("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        do_request(65, 0, 1'b0, 1'b0, 1'b0, vc);
        check("req65_coins", vc, 4);
        check("req65_inv_q", int'(inv_q), 18);
        check("req65_inv_d", int'(inv_d), 19);
        check("req65_inv_n", int'(inv_n), 19);
        check_inv("req65");

        do_request(25, 3, 1'b0, 1'b0, 1'b1, vc);
        check("req25_stall_valid_cycles", vc, 4);
        check_inv("req25_stall");

        do_request(25, 0, 1'b0, 1'b1, 1'b0, vc);
        check("refill_dispense_inv_q", int'(inv_q), 17);
        check_inv("refill_dispense");

        refill(ILLEGALCOIN, 2);
        check_inv("illegal_refill");

        do_request(0, 0, 1'b0, 1'b0, 1'b0, vc);
        check("zero_no_coin", vc, 0);

        do_request(43, 0, 1'b0, 1'b0, 1'b0, vc);
        check("req43_coins", vc, 3);
        check_inv("req43");

        guard = 0;
        while (m_inv[0] > 0 && guard < 40) begin
            do_request(5, 0, 1'b1, 1'b0, 1'b0, vc);
            guard++;
        end
        check("nickels_drained", int'(inv_n), 0);
        do_request(30, 0, 1'b0, 1'b0, 1'b0, vc);
        check("req30_no_nickel_coins", vc, 1);
        refill(NICKEL, 20);
        check_inv("nickel_refill");

        refill(QUARTER, INV_MAX - m_inv[2]);
        check("sat_inv_q", int'(inv_q), 255);
        refill(QUARTER, 1);
        check("sat_hold_inv_q", int'(inv_q), 255);
        check_inv("saturate");

        for (int i = 0; i < 40; i++) begin
            for (int k = $urandom_range(0, 3); k > 0; k--) refill(2'($urandom_range(0, 3)), 1);
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120);
            do_request(amt, 0, 1'b1, 1'b0, 1'b0, vc);
        end
        check_inv("random");

        // Abort a request in DISPENSE with an asynchronous reset.
        refill(QUARTER, 1);
        guard = 0;
        model_request(25);
        req_valid  = 1'b1;
        req_amount = 8'd25;
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!coin_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("abort_reached_dispense", int'(coin_valid), 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_reset();
        check("abort_coin_valid", int'(coin_valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_coin_out", int'(coin_out), int'(NICKEL));
        check("abort_state", int'(state), 0);
        check_inv("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_req_ready", int'(req_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", int'(done), 0);

        for (int i = 0; i < 6; i++) begin
            do_request($urandom_range(0, 150), 0, 1'b1, 1'b0, 1'b0, vc);
        end
        check_inv("final");
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
